// File: rtl/axis_dwidth_pkg.sv
// Shared definitions for the AXI4-Stream width converter pair.
package axis_dwidth_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REG = 2;

  // Width of a lane index; a single-lane word still needs one bit.
  function automatic int lane_idx_w(input int num_reg);
    return (num_reg > 1) ? $clog2(num_reg) : 1;
  endfunction

  // Wide beat at the default geometry; parameterized users declare the same shape locally.
  typedef struct packed {
    logic [DEF_WIDTH*DEF_NUM_REG-1:0] data;
    logic [DEF_NUM_REG-1:0]           keep;
    logic                             last;
  } wide_beat_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry output register with a valid/ready handshake.
// A load in the same cycle as a drain replaces the held beat and keeps valid high.
module axis_out_reg
  import axis_dwidth_pkg::*;
#(
  parameter type beat_t = wide_beat_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  beat_t d,
  input  logic  ready,
  output logic  valid,
  output beat_t q
);

  // Hold the beat until the consumer takes it; a new load always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_dwidth_upsizer.sv
// AXI4-Stream upsizer: packs NUM_REG narrow beats into one wide beat, lane 0 first.
// A beat carrying tlast closes the word early; unfilled lanes read 0 with keep 0.
module axis_dwidth_upsizer
  import axis_dwidth_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REG = DEF_NUM_REG
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [WIDTH-1:0]         s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [WIDTH*NUM_REG-1:0] m_axis_tdata,
  output logic [NUM_REG-1:0]       m_axis_tkeep,
  output logic                     m_axis_tlast
);

  localparam int LANE_IDX_W = lane_idx_w(NUM_REG);

  typedef struct packed {
    logic [WIDTH*NUM_REG-1:0] data;
    logic [NUM_REG-1:0]       keep;
    logic                     last;
  } beat_t;

  logic [WIDTH*NUM_REG-1:0] acc_data, nxt_data;
  logic [NUM_REG-1:0]       acc_keep, nxt_keep;
  logic [LANE_IDX_W-1:0]    cnt;
  logic                     complete, accept, load;
  beat_t                    word, out_q;

  // Current beat merged into the accumulator; also the word handed to the output register.
  always_comb begin
    nxt_data = acc_data;
    nxt_keep = acc_keep;
    nxt_data[cnt*WIDTH +: WIDTH] = s_axis_tdata;
    nxt_keep[cnt]                = 1'b1;
  end

  // Only a completing beat can be stalled, and only by a full, undrained output.
  assign complete      = (cnt == LANE_IDX_W'(NUM_REG-1)) || s_axis_tlast;
  assign s_axis_tready = !complete || !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load          = accept && complete;

  assign word.data = nxt_data;
  assign word.keep = nxt_keep;
  assign word.last = s_axis_tlast;

  // Accumulate lanes; a completed word empties the accumulator back to lane 0.
  always_ff @(posedge aclk) begin
    if (areset) begin
      acc_data <= '0;
      acc_keep <= '0;
      cnt      <= '0;
    end else if (accept) begin
      if (complete) begin
        acc_data <= '0;
        acc_keep <= '0;
        cnt      <= '0;
      end else begin
        acc_data <= nxt_data;
        acc_keep <= nxt_keep;
        cnt      <= cnt + 1'b1;
      end
    end
  end

  axis_out_reg #(.beat_t(beat_t)) u_out_reg (
    .clk   (aclk),
    .rst   (areset),
    .load  (load),
    .d     (word),
    .ready (m_axis_tready),
    .valid (m_axis_tvalid),
    .q     (out_q)
  );

  assign m_axis_tdata = out_q.data;
  assign m_axis_tkeep = out_q.keep;
  assign m_axis_tlast = out_q.last;

endmodule

// File: tb/tb_axis_dwidth_upsizer.sv
// Scoreboard bench for axis_dwidth_upsizer (WIDTH=32, NUM_REG=2).
module tb_axis_dwidth_upsizer;

  localparam int W = 32;
  localparam int N = 2;

  typedef struct packed {
    logic [W*N-1:0] data;
    logic [N-1:0]   keep;
    logic           last;
  } exp_t;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic [W-1:0]   s_tdata = '0;
  logic           s_tlast = 1'b0;
  logic           m_tvalid;
  logic           m_tready = 1'b1;
  logic [W*N-1:0] m_tdata;
  logic [N-1:0]   m_tkeep;
  logic           m_tlast;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 aclk = ~aclk;

  axis_dwidth_upsizer #(.WIDTH(W), .NUM_REG(N)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast)
  );

  task automatic chk(input string nm, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W*N-1:0] d, input logic [N-1:0] k, input logic l);
    exp_t e;
    e.data = d; e.keep = k; e.last = l;
    sb.push_back(e);
  endtask

  // Drive one narrow beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic l, output int stalls);
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    stalls = 0;
    @(negedge aclk);
    while (!s_tready && stalls < 200) begin
      @(negedge aclk);
      stalls++;
    end
    if (stalls >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat %h never accepted", d);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge aclk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  // Monitor: every handshaken wide beat must match the head of the scoreboard.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %h keep %b, expected none", m_tdata, m_tkeep);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", m_tdata, e.data);
        chk("out_keep", {{(W*N-N){1'b0}}, m_tkeep}, {{(W*N-N){1'b0}}, e.keep});
        chk("out_last", {{(W*N-1){1'b0}}, m_tlast}, {{(W*N-1){1'b0}}, e.last});
      end
    end
  end

  initial begin
    int st;
    logic [W*N-1:0] wd, step;

    // Reset state
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_tkeep", {62'd0, m_tkeep}, 64'd0);
    chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_tready", {63'd0, s_tready}, 64'd1);
    @(posedge aclk); #1;

    // 1: full word, one-cycle latency
    push(64'h00000001_00000064, 2'b11, 1'b1);
    send(32'h64, 1'b0, st);
    send(32'h01, 1'b1, st);
    chk("t1_latency_valid", {63'd0, m_tvalid}, 64'd1);
    wait_drain();

    // 2: partial word closed by tlast, next word restarts at lane 0
    push(64'h00000000_DEADBEEF, 2'b01, 1'b1);
    send(32'hDEADBEEF, 1'b1, st);
    chk("t2_latency_valid", {63'd0, m_tvalid}, 64'd1);
    push(64'h00000006_00000005, 2'b11, 1'b1);
    send(32'h5, 1'b0, st);
    send(32'h6, 1'b1, st);
    wait_drain();

    // 3: backpressure stalls only the completing beat
    m_tready = 1'b0;
    push(64'h00000002_00000001, 2'b11, 1'b1);
    send(32'h1, 1'b0, st);
    send(32'h2, 1'b1, st);
    send(32'hA, 1'b0, st);
    chk("t3_nocomplete_nostall", st, 0);
    s_tvalid = 1'b1; s_tdata = 32'hB; s_tlast = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      chk("t3_stall_tready", {63'd0, s_tready}, 64'd0);
      chk("t3_hold_data", m_tdata, 64'h00000002_00000001);
    end
    @(posedge aclk); #1;
    m_tready = 1'b1;
    push(64'h0000000B_0000000A, 2'b11, 1'b0);
    send(32'hB, 1'b0, st);
    chk("t3_reload_valid", {63'd0, m_tvalid}, 64'd1);
    push(64'h00000000_0000000C, 2'b01, 1'b1);
    send(32'hC, 1'b1, st);
    wait_drain();

    // 4: streaming, never stalled
    for (int i = 1; i <= 8; i += 2)
      push({32'(i + 1), 32'(i)}, 2'b11, i == 7);
    for (int i = 1; i <= 8; i++) begin
      send(32'(i), i == 8, st);
      chk("t4_no_stall", st, 0);
    end
    wait_drain();

    // 5: reset mid-packet discards the partial word
    send(32'h11, 1'b0, st);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("t5_tvalid_after_rst", {63'd0, m_tvalid}, 64'd0);
    chk("t5_tready_after_rst", {63'd0, s_tready}, 64'd1);
    @(posedge aclk); #1;
    push(64'h00000033_00000022, 2'b11, 1'b1);
    send(32'h22, 1'b0, st);
    send(32'h33, 1'b1, st);
    wait_drain();

    // 6: round trip of wide words split low-lane first
    step = 64'h00000001_00000010;
    wd   = 64'h00000001_00000064;
    for (int i = 0; i < 20; i++) begin
      push(wd, 2'b11, i == 19);
      send(wd[W-1:0], 1'b0, st);
      send(wd[W*N-1:W], i == 19, st);
      wd = wd + step;
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
